// File: rtl/mac_pkg.sv
// Shared widths, saturation limits and the multiplier-latency tag type for the
// signed multiply-accumulate controller.
package mac_pkg;

  localparam int ACC_W       = 64;
  localparam int OP_W        = 32;
  localparam int MUL_LAT_DEF = 2;

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic v;
    logic last;
  } tag_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// Fixed-length shift register of {valid,last} tags that tracks operand pairs
// through the external multiplier; it never stalls, mirroring the multiplier.
module mac_tag_pipe
  import mac_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_v,
  input  logic in_last,
  output logic out_v,
  output logic out_last,
  output logic any_last
);

  tag_t [MUL_LAT-1:0] stage_q;
  tag_t [MUL_LAT-1:0] stage_d;

  always_comb begin
    stage_d[0] = '{v: in_v, last: in_last};
    for (int i = 1; i < MUL_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking would collapse the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    any_last = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) begin
      any_last = any_last | (stage_q[i].v & stage_q[i].last);
    end
  end

  assign out_v    = stage_q[MUL_LAT-1].v;
  assign out_last = stage_q[MUL_LAT-1].last;

endmodule

// File: rtl/mac_accumulator.sv
// Signed MAC controller around an external registered multiplier.
// Define MAC_SAT_EN to clamp the running sum on overflow instead of wrapping.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_a,
  input  logic [OP_W-1:0]    in_b,
  input  logic               in_last,
  output logic [OP_W-1:0]    mul_a,
  output logic [OP_W-1:0]    mul_b,
  input  logic [ACC_W-1:0]   mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf
);

  logic               accept;
  logic               tag_v, tag_last, last_in_flight;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               first_n_q, first_n_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;
  logic [ACC_W-1:0]   raw_sum, sum_val;
  logic [CNT_W-1:0]   count_inc;
  logic               add_ovf;

  assign mul_a  = in_a;
  assign mul_b  = in_b;
  // in_ready depends only on registered state, so a held result can never be
  // overwritten by a last term accepted behind it.
  assign in_ready = ~out_valid_q & ~last_in_flight;
  assign accept   = in_valid & in_ready;

  mac_tag_pipe #(.MUL_LAT(MUL_LAT)) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_v     (accept),
    .in_last  (in_last & accept),
    .out_v    (tag_v),
    .out_last (tag_last),
    .any_last (last_in_flight)
  );

  always_comb begin
    raw_sum   = acc_q + mul_p;
    add_ovf   = first_n_q & (acc_q[ACC_W-1] == mul_p[ACC_W-1])
                          & (raw_sum[ACC_W-1] != acc_q[ACC_W-1]);
    count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    if (!first_n_q) begin
      sum_val = mul_p;
    end else begin
`ifdef MAC_SAT_EN
      sum_val = add_ovf ? (acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw_sum;
`else
      sum_val = raw_sum;
`endif
    end
  end

  // NOTE: every always_comb target gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    first_n_d   = first_n_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (tag_v) begin
      if (tag_last) begin
        out_sum_d   = sum_val;
        out_count_d = count_inc;
        out_ovf_d   = ovf_q | add_ovf;
        out_valid_d = 1'b1;
        acc_d       = '0;
        count_d     = '0;
        ovf_d       = 1'b0;
        first_n_d   = 1'b0;
      end else begin
        acc_d       = sum_val;
        count_d     = count_inc;
        ovf_d       = ovf_q | add_ovf;
        first_n_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      first_n_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      first_n_q   <= first_n_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a two-stage registered signed
// multiplier alongside it; honours MAC_SAT_EN for the overflow expectation.
module tb_mac_accumulator;

  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_a = '0, in_b = '0;
  logic               in_last = 1'b0;
  logic [31:0]        mul_a, mul_b;
  logic [63:0]        mul_p;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [63:0]        out_sum;
  logic [CNT_W-1:0]   out_count;
  logic               out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.MUL_LAT(2), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // Multiplier environment: input register then output register, no reset.
  logic signed [31:0] a_r, b_r;
  logic signed [63:0] p_r;
  always_ff @(posedge clk) begin
    a_r <= mul_a;
    b_r <= mul_b;
    p_r <= a_r * b_r;
  end
  assign mul_p = p_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair and returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [63:0] sum, input logic [63:0] cnt,
                          input logic ovf);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sum"},   out_sum,   sum);
    check({tag, "_count"}, out_count, cnt);
    check({tag, "_ovf"},   out_ovf,   ovf);
  endtask

  initial begin
    #12;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum",   out_sum,   64'd0);
    check("rst_out_count", out_count, 64'd0);
    check("rst_out_ovf",   out_ovf,   1'b0);
    rst_n = 1'b1;
    tick();

    // Three-term group: 12 - 30 + 56 = 38, result two edges after last accept.
    send(32'd3, 32'd4, 1'b0);
    send(-32'sd5, 32'd6, 1'b0);
    send(32'd7, 32'd8, 1'b1);
    check("grp_ready_blocked", in_ready, 1'b0);
    check("grp_valid_k0", out_valid, 1'b0);
    tick();
    check("grp_valid_k1", out_valid, 1'b0);
    tick();
    check("grp_valid_k2", out_valid, 1'b1);
    check("grp_sum",   out_sum,   64'd38);
    check("grp_count", out_count, 64'd3);
    check("grp_ovf",   out_ovf,   1'b0);
    tick();
    check("grp_valid_drop", out_valid, 1'b0);
    check("grp_ready_back", in_ready,  1'b1);

    send(-32'sd2, 32'd3, 1'b1);
    wait_out("single", 64'hFFFF_FFFF_FFFF_FFFA, 64'd1, 1'b0);
    tick();

    // Backpressure: held result must not move and must block new pairs.
    out_ready = 1'b0;
    send(32'd10, 32'd10, 1'b1);
    wait_out("bp", 64'd100, 64'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", in_ready,  1'b0);
      check("bp_valid",    out_valid, 1'b1);
      check("bp_sum",      out_sum,   64'd100);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready,  1'b1);
    send(32'd1, 32'd1, 1'b1);
    wait_out("bp_next", 64'd1, 64'd1, 1'b0);
    tick();

    // (-2^31)^2 = 2^62, twice gives 2^63: positive overflow.
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b1);
`ifdef MAC_SAT_EN
    wait_out("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
`else
    wait_out("ovf", 64'h8000_0000_0000_0000, 64'd2, 1'b1);
`endif
    tick();

    // Reset with two non-last terms in flight: products are stale and dropped.
    send(32'd5, 32'd5, 1'b0);
    send(32'd6, 32'd6, 1'b0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_ready", in_ready,  1'b1);
    check("mid_rst_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    send(32'd1, 32'd1, 1'b1);
    wait_out("after_rst", 64'd1, 64'd1, 1'b0);
    tick();

    // Back-to-back last-only groups.
    send(32'd1, 32'd1, 1'b1);
    wait_out("b2b_0", 64'd1, 64'd1, 1'b0);
    send(32'd2, 32'd2, 1'b1);
    wait_out("b2b_1", 64'd4, 64'd1, 1'b0);
    tick();
    check("b2b_idle_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Signed multiply-accumulate controller wrapped around the registered 32x32 tree multiplier. Accepts operand pairs over a valid/ready handshake, drives them to the multiplier, tracks the fixed multiplier latency with a tag pipeline, and accumulates the 64-bit signed products into a running sum. On the last term of a group it presents the sum and term count through an output valid/ready handshake.

## Interface
- MUL_LAT, 2, cycles from operand capture edge to product valid at the multiplier output (input reg + output reg)
- CNT_W, 16, term counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts pair this cycle
- in_a, in_b  in  32 each  signed operands
- in_last  in  1  pair is final term of group
- mul_a, mul_b  out  32 each  to multiplier inputs; combinational copy of in_a/in_b
- mul_p  in  64  product from multiplier output register
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts result
- out_sum  out  64  signed group sum
- out_count  out  CNT_W  terms in group
- out_ovf  out  1  sticky overflow flag for group

## Operation
- Accept = in_valid & in_ready. in_ready = ~out_valid & ~(any last tag in flight).
- Tag pipeline: MUL_LAT stages of {v, last}. Stage 0 loads {accept, in_last & accept}; shifts every cycle, never stalls (multiplier has no stall).
- Consume when final stage v=1: term = mul_p.
  - first_n=0 (first term): acc ← term; else acc ← acc + term. count ← count+1, saturating at 2^CNT_W−1.
  - Final stage last=1: out_sum ← computed sum, out_count ← new count, out_ovf ← group flag, out_valid ← 1; acc, count, ovf, first cleared.
- Overflow: signed 64-bit add overflow (operand signs equal, result sign differs). Behaviour per Configuration.
- out_valid clears on out_valid & out_ready; out_sum/count/ovf hold until then.
- Non-last terms never stall on a held result; last terms block new accepts so a held result is never overwritten.
- Reset mid-operation: tags cleared, so stale products in the unreset multiplier registers are ignored; partial group discarded.

## Timing
- Reset values: in_ready 1, out_valid 0, out_sum 0, out_count 0, out_ovf 0; acc, count, tags 0.
- Pair accepted at edge k → product sampled at edge k+MUL_LAT → for a last term, out_valid high after edge k+MUL_LAT.
- Full throughput: one pair per cycle within a group; after accepting a last, in_ready low until out_valid drops (minimum MUL_LAT+1 cycles with out_ready held 1).
- out_valid & out_ready at edge e: out_valid low after e; in_ready high the same cycle out_valid drops.

## Configuration
- MAC_SAT_EN defined: on overflow acc clamps to 0x7FFF_FFFF_FFFF_FFFF (positive) or 0x8000_0000_0000_0000 (negative), ovf set sticky; saturated value continues accumulating.
- Undefined: two's-complement wrap modulo 2^64; ovf still flagged sticky.

## Structure
- Package mac_pkg: ACC_W=64, OP_W=32, default MUL_LAT, SAT_MAX/SAT_MIN constants, tag struct {v,last}.
- One sub-module: mac_tag_pipe (parameterised MUL_LAT shift register of tags, async reset).
- Multiplier instantiated by the parent, not inside this block.

## Test plan
- Group (3,4),(−5,6),(7,8 last), out_ready=1 → out_sum=38, out_count=3, out_ovf=0, out_valid 2 cycles after third accept.
- Single term (−2,3 last) → out_sum=−6 (0xFFFF_FFFF_FFFF_FFFA), count 1.
- Backpressure: out_ready=0 for 5 cycles after result → in_ready low, out_sum stable; out_ready=1 → in_ready high, next group 1*1 last → 1.
- Overflow: (0x8000_0000,0x8000_0000) twice, last → with MAC_SAT_EN 0x7FFF_FFFF_FFFF_FFFF ovf=1; without 0x8000_0000_0000_0000 ovf=1.
- Reset mid-group: accept (5,5),(6,6), pulse rst_n low 1 cycle, then (1,1 last) → out_sum=1, count 1.
- Back-to-back groups (1,1 last),(2,2 last) with out_ready=1 → sums 1 then 4, no lost or merged results.
